// File: rtl/keypad_event_queue_if.sv
// Register-bus and scanner-sample bundle for keypad_event_queue.
// master: the side driving the scanner samples and the CPU strobes.
// slave:  keypad_event_queue itself.
interface keypad_event_queue_if;
  logic        sample_tick;
  logic [7:0]  key_code;
  logic [2:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output sample_tick, key_code, addr, wr_en, rd_en, wdata,
    input  rdata, irq
  );

  modport slave (
    input  sample_tick, key_code, addr, wr_en, rd_en, wdata,
    output rdata, irq
  );
endinterface

// File: rtl/keypad_event_queue.sv
// keypad_event_queue: debounces the scanner's per-frame key code, queues one
// event per new press in a small FIFO and exposes it on a byte-wide register
// bus (DATA=0, STATUS=1, CTRL=2) with a registered level interrupt.
// Optional auto-repeat is compiled in when KEYPAD_REPEAT_EN is defined.
module keypad_event_queue #(
  parameter int DEPTH        = 8,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_TICKS = 32
) (
  input logic                 clk,
  input logic                 rst,
  keypad_event_queue_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [7:0] DEB8 = 8'(DEBOUNCE);

  // Debounce state
  logic [7:0] last_code_q, last_code_d;
  logic [7:0] stable_cnt_q, stable_cnt_d;
  logic [7:0] accepted_code_q, accepted_code_d;
  logic       accept_hit;
  logic       deb_push;
  logic       push_req;

  // FIFO and register state
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          irq_en_q, irq_en_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          irq_q, irq_d;

  logic       empty, full, pop, flush, ovf_clr, push_ok;
  logic [7:0] count_ext;
  logic [3:0] count_sat;
  logic       unused_wdata;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign pop          = bus.rd_en && (bus.addr == 3'd0) && !empty;
  assign flush        = bus.wr_en && (bus.addr == 3'd2) && bus.wdata[1];
  assign ovf_clr      = bus.wr_en && (bus.addr == 3'd1) && bus.wdata[2];
  assign push_ok      = push_req && !full && !flush;
  assign count_ext    = 8'(count_q);
  assign count_sat    = (count_ext > 8'd15) ? 4'hF : count_ext[3:0];
  assign unused_wdata = ^bus.wdata[31:3];

  // Debounce: track the last code, count identical ticks, accept at DEBOUNCE
  always_comb begin
    last_code_d     = last_code_q;
    stable_cnt_d    = stable_cnt_q;
    accepted_code_d = accepted_code_q;
    accept_hit      = 1'b0;
    deb_push        = 1'b0;
    if (bus.sample_tick) begin
      if (bus.key_code != last_code_q) begin
        last_code_d  = bus.key_code;
        stable_cnt_d = 8'd1;
      end else begin
        if (stable_cnt_q < DEB8) stable_cnt_d = stable_cnt_q + 8'd1;
        if (stable_cnt_q == DEB8 - 8'd1) begin
          accept_hit      = 1'b1;
          accepted_code_d = last_code_q;
          // A stable zero re-arms the same key by clearing accepted_code
          deb_push = (last_code_q != 8'h00) && (last_code_q != accepted_code_q);
        end
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [7:0] RPT8 = 8'(REPEAT_TICKS);
  logic [7:0] rpt_cnt_q, rpt_cnt_d;
  logic       rpt_push;

  // Auto-repeat: re-push the held code every REPEAT_TICKS ticks after acceptance
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_push  = 1'b0;
    if (bus.sample_tick) begin
      if (bus.key_code != last_code_q || accept_hit) begin
        rpt_cnt_d = 8'd0;
      end else if (accepted_code_q != 8'h00 && bus.key_code == accepted_code_q) begin
        if (rpt_cnt_q == RPT8 - 8'd1) begin
          rpt_push  = 1'b1;
          rpt_cnt_d = 8'd0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 8'd1;
        end
      end
    end
  end

  // Repeat counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rpt_cnt_q <= 8'd0;
    else     rpt_cnt_q <= rpt_cnt_d;
  end

  assign push_req = deb_push | rpt_push;
`else
  assign push_req = deb_push;
`endif

  // FIFO pointers, count, sticky overflow, control and read-data next state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    irq_en_d   = irq_en_q;
    rdata_d    = rdata_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
      if (pop)     rd_ptr_d = AW'(rd_ptr_q + 1'b1);
      case ({push_ok, pop})
        2'b10:   count_d = CW'(count_q + 1'b1);
        2'b01:   count_d = CW'(count_q - 1'b1);
        default: count_d = count_q;
      endcase
      // A new overflow wins over a simultaneous clear
      if (push_req && full) overflow_d = 1'b1;
      else if (ovf_clr)     overflow_d = 1'b0;
    end
    if (bus.wr_en && bus.addr == 3'd2) irq_en_d = bus.wdata[0];
    if (bus.rd_en) begin
      case (bus.addr)
        3'd0:    rdata_d = empty ? 32'd0 : {24'd0, mem[rd_ptr_q]};
        3'd1:    rdata_d = {24'd0, count_sat, 1'b0, overflow_q, full, empty};
        3'd2:    rdata_d = {31'd0, irq_en_q};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  assign irq_d = irq_en_q & ~empty;

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_code_q     <= 8'h00;
      stable_cnt_q    <= 8'd0;
      accepted_code_q <= 8'h00;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      overflow_q      <= 1'b0;
      irq_en_q        <= 1'b0;
      rdata_q         <= 32'd0;
      irq_q           <= 1'b0;
    end else begin
      last_code_q     <= last_code_d;
      stable_cnt_q    <= stable_cnt_d;
      accepted_code_q <= accepted_code_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      overflow_q      <= overflow_d;
      irq_en_q        <= irq_en_d;
      rdata_q         <= rdata_d;
      irq_q           <= irq_d;
    end
  end

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= last_code_q;
  end

  assign bus.rdata = rdata_q;
  assign bus.irq   = irq_q;
endmodule

// File: tb/tb_keypad_event_queue.sv
// Self-checking bench for keypad_event_queue: a queue of expected key events
// is filled as presses are driven and drained as DATA reads come back.
module tb_keypad_event_queue;
  localparam int DEPTH = 8;
  localparam int DEB   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  keypad_event_queue_if bus ();

  keypad_event_queue #(.DEPTH(DEPTH), .DEBOUNCE(DEB), .REPEAT_TICKS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [7:0] code);
    bus.key_code    = code;
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    step();
  endtask

  task automatic hold(input logic [7:0] code, input int n);
    repeat (n) tick(code);
  endtask

  task automatic expect_push(input logic [7:0] code);
    if (sb.size() < DEPTH) sb.push_back(code);
  endtask

  task automatic press(input logic [7:0] code);
    hold(code, DEB);
    expect_push(code);
    hold(8'h00, DEB);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] v);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    v = bus.rdata;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.wr_en = 1'b1;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] v;
    logic [31:0] exp;
    read_reg(3'd0, v);
    exp = (sb.size() > 0) ? {24'd0, sb.pop_front()} : 32'd0;
    check(tag, v, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] exp;
    bus.sample_tick = 1'b0;
    bus.key_code    = 8'h00;
    bus.addr        = 3'd0;
    bus.wr_en       = 1'b0;
    bus.rd_en       = 1'b0;
    bus.wdata       = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    read_reg(3'd1, v);
    check("rst_status", v, 32'h01);

    // Bounce: 31,00,31,31,31 must not yet produce an event
    tick(8'h31); tick(8'h00); tick(8'h31); tick(8'h31); tick(8'h31);
    read_reg(3'd1, v);
    check("bounce_pre_status", v, 32'h01);
    tick(8'h31);
    expect_push(8'h31);
    read_reg(3'd1, v);
    check("bounce_status", v, 32'h10);
    hold(8'h00, DEB);
    pop_check("bounce_data");
    read_reg(3'd1, v);
    check("bounce_empty", v, 32'h01);

    // Hold then release then press again: two events
    hold(8'h32, 10); expect_push(8'h32);
    hold(8'h00, 4);
    hold(8'h32, 4);  expect_push(8'h32);
    hold(8'h00, 4);
    read_reg(3'd1, v);
    check("hold_status", v, 32'h20);
    pop_check("hold_data0");
    pop_check("hold_data1");
    pop_check("hold_data_empty");
    read_reg(3'd1, v);
    check("hold_empty", v, 32'h01);

    // Overflow: nine distinct presses into eight entries
    for (int i = 0; i < 9; i++) press(8'h41 + 8'(i));
    read_reg(3'd1, v);
    check("ovf_status", v, 32'h86);
    write_reg(3'd1, 32'h4);
    read_reg(3'd1, v);
    check("ovf_cleared", v, 32'h82);
    for (int i = 0; i < DEPTH; i++) pop_check($sformatf("ovf_data%0d", i));
    read_reg(3'd1, v);
    check("ovf_drained", v, 32'h01);

    // IRQ rise one cycle after push, fall after the pop
    write_reg(3'd2, 32'h1);
    read_reg(3'd2, v);
    check("ctrl_irq_en", v, 32'h1);
    hold(8'h51, DEB - 1);
    bus.key_code    = 8'h51;
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    expect_push(8'h51);
    check("irq_pre", {31'd0, bus.irq}, 32'd0);
    step();
    check("irq_rise", {31'd0, bus.irq}, 32'd1);
    pop_check("irq_data");
    check("irq_hold", {31'd0, bus.irq}, 32'd1);
    step();
    check("irq_fall", {31'd0, bus.irq}, 32'd0);
    hold(8'h00, DEB);

    // Push and pop on the same cycle with three entries queued
    press(8'h61); press(8'h62); press(8'h63);
    hold(8'h64, DEB - 1);
    bus.key_code    = 8'h64;
    bus.sample_tick = 1'b1;
    bus.addr        = 3'd0;
    bus.rd_en       = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    bus.rd_en       = 1'b0;
    v   = bus.rdata;
    exp = {24'd0, sb.pop_front()};
    check("simul_head", v, exp);
    expect_push(8'h64);
    read_reg(3'd1, v);
    check("simul_status", v, 32'h30);
    for (int i = 0; i < 3; i++) pop_check($sformatf("simul_data%0d", i));
    hold(8'h00, DEB);

    // Flush on the same cycle as a push
    press(8'h70);
    hold(8'h71, DEB - 1);
    bus.key_code    = 8'h71;
    bus.sample_tick = 1'b1;
    bus.addr        = 3'd2;
    bus.wdata       = 32'h2;
    bus.wr_en       = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    bus.wr_en       = 1'b0;
    sb.delete();
    read_reg(3'd1, v);
    check("flush_status", v, 32'h01);
    read_reg(3'd2, v);
    check("flush_ctrl", v, 32'h0);
    hold(8'h00, DEB);

    // Asynchronous reset mid-debounce with two entries queued
    write_reg(3'd2, 32'h1);
    press(8'h81); press(8'h82);
    read_reg(3'd1, v);
    check("prerst_status", v, 32'h20);
    check("prerst_irq", {31'd0, bus.irq}, 32'd1);
    hold(8'h83, 2);
    #3 rst = 1'b1;
    #1;
    check("arst_rdata", bus.rdata, 32'd0);
    check("arst_irq", {31'd0, bus.irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    read_reg(3'd1, v);
    check("arst_status", v, 32'h01);
    hold(8'h00, DEB);
    read_reg(3'd1, v);
    check("arst_no_event", v, 32'h01);
    pop_check("arst_data_empty");
    check("arst_irq_after", {31'd0, bus.irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
